pic_rom_fetch: RTL

PIC_ROM_FETCH -- requirements
Module: pic_rom_fetch

---
 rtl/pic_disp_pkg.sv | 27 ++
 rtl/pic_delay_line.sv | 25 ++
 rtl/pic_rom_fetch.sv | 111 +++++++++++
 3 files changed

// File: rtl/pic_disp_pkg.sv
// Shared constants and the aligned sync/window bundle for the picture-ROM display path.
package pic_disp_pkg;

    localparam int IMG_W   = 256;
    localparam int IMG_H   = 256;
    localparam int ROM_LAT = 2;
    localparam int PIX_W   = 24;
    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 12;

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
        logic win;
        logic border;
    } sync_t;

    localparam int SYNC_W = $bits(sync_t);

    // True when lo <= c < lo+len and c < lim (lim clips the window to the active area).
    function automatic logic in_span(input logic [CNT_W-1:0] c, input int lo,
                                     input int len, input int lim);
        return (int'(c) >= lo) && (int'(c) < lo + len) && (int'(c) < lim);
    endfunction

endpackage

// File: rtl/pic_delay_line.sv
// Fixed DEPTH-stage register pipeline, synchronously cleared; no backpressure.
module pic_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/pic_rom_fetch.sv
// Overlays a 256x256 ROM picture on a video stream; 3 clk latency, no backpressure.
// Optional PIC_ROM_FETCH_BORDER_EN draws a white one-pixel frame around the picture.
module pic_rom_fetch
    import pic_disp_pkg::*;
#(
    parameter int               H_ACT    = 1920,
    parameter int               V_ACT    = 1080,
    parameter int               IMG_X    = 832,
    parameter int               IMG_Y    = 412,
    parameter logic [PIX_W-1:0] BG_COLOR = 24'h000000,
    parameter bit               VS_POL   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [PIX_W-1:0]  rgb_out
);

    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic             vs_prev;
    logic             de_prev;
    logic             locked;

    logic             vs_lead;
    logic             de_fall;
    logic             in_win;
    logic             border;
    logic [CNT_W-1:0] x_off;
    logic [CNT_W-1:0] y_off;
    logic [7:0]       x_rel;
    logic [7:0]       y_rel;

    sync_t            s_in;
    sync_t            s_out;

    assign vs_lead = (vs_in == VS_POL) && (vs_prev != VS_POL);
    assign de_fall = de_prev && !de_in;

    assign x_off = x_cnt - CNT_W'(IMG_X);
    assign y_off = y_cnt - CNT_W'(IMG_Y);
    assign x_rel = x_off[7:0];
    assign y_rel = y_off[7:0];

    assign in_win = locked && de_in
                 && in_span(x_cnt, IMG_X, IMG_W, H_ACT)
                 && in_span(y_cnt, IMG_Y, IMG_H, V_ACT);

`ifdef PIC_ROM_FETCH_BORDER_EN
    assign border = in_win && (x_rel == 8'h00 || x_rel == 8'hFF ||
                               y_rel == 8'h00 || y_rel == 8'hFF);
`else
    assign border = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            vs_prev  <= 1'b0;
            de_prev  <= 1'b0;
            locked   <= 1'b0;
            rom_addr <= '0;
        end else begin
            x_cnt   <= de_in ? x_cnt + CNT_W'(1) : '0;
            vs_prev <= vs_in;
            de_prev <= de_in;
            // Frame start wins over a coincident end of line so the new frame starts at line 0.
            if (vs_lead) begin
                y_cnt  <= '0;
                locked <= 1'b1;
            end else if (de_fall) begin
                y_cnt <= y_cnt + CNT_W'(1);
            end
            if (in_win) rom_addr <= {y_rel, x_rel};
        end
    end

    assign s_in = '{vs: vs_in, hs: hs_in, de: de_in, win: in_win, border: border};

    pic_delay_line #(
        .DEPTH (ROM_LAT + 1),
        .WIDTH (SYNC_W)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (s_in),
        .dout  (s_out)
    );

    assign vs_out = s_out.vs;
    assign hs_out = s_out.hs;
    assign de_out = s_out.de;

    // rom_data arrives already aligned with the delayed flags, so the final mux is combinational.
    always_comb begin
        rgb_out = '0;
        if (s_out.win)
            rgb_out = s_out.border ? 24'hFFFFFF : rom_data;
        else if (s_out.de)
            rgb_out = BG_COLOR;
    end

endmodule
